// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = 6;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic f3_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic f3_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation; used for |x| on the way in and
// for restoring the sign of the result on the way out.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? ((~i_val) + W'(1)) : i_val;

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, sharing a single 2*XLEN accumulator.
//
// state | meaning
// IDLE  | waiting for start; operands sampled on the accept edge
// CALC  | XLEN iterations of shift-add or restoring divide
// FIX   | sign correction / word select (or special-case value) into result
// DONE  | one-cycle done pulse, result and rd_out valid
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            wb_en,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic              r_neg;
  logic              r_special;
  logic [XLEN-1:0]   r_spec_val;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_sa, w_sb;
  logic [XLEN-1:0]   w_abs_a, w_abs_b;
  logic              w_is_div;
  logic              w_div_zero, w_ovf, w_special;
  logic [XLEN-1:0]   w_spec_val;

  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN+1:0]   w_diff;
  logic              w_qbit;
  logic [2*XLEN-1:0] w_div_next;

  logic [2*XLEN-1:0] w_fix_in, w_fixed;
  logic [XLEN-1:0]   w_fix_word;

  // ---------------- operand preparation ----------------
  assign w_sa     = f3_a_signed(funct3) & op_a[XLEN-1];
  assign w_sb     = f3_b_signed(funct3) & op_b[XLEN-1];
  assign w_is_div = funct3[2];

  mdu_sign_fix #(.W(XLEN)) u_abs_a (.i_val(op_a), .i_neg(w_sa), .o_val(w_abs_a));
  mdu_sign_fix #(.W(XLEN)) u_abs_b (.i_val(op_b), .i_neg(w_sb), .o_val(w_abs_b));

  // Divide by zero and INT_MIN / -1 skip the iterations entirely
  assign w_div_zero = w_is_div && (op_b == '0);
  assign w_ovf      = (funct3 == F3_DIV || funct3 == F3_REM) &&
                      (op_a == INT_MIN) && (op_b == '1);
  assign w_special  = w_div_zero || w_ovf;

  // funct3[1] separates REM/REMU from DIV/DIVU
  assign w_spec_val = w_div_zero ? (funct3[1] ? op_a : '1)
                                 : (funct3[1] ? '0   : INT_MIN);

  assign w_accept = (r_state == IDLE) && start && !kill;

  // ---------------- iteration step ----------------
  // Multiply: multiplier sits in the low word and is consumed LSB first
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                      (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: remainder in the high word, dividend/quotient in the low word
  assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_opnd};
  assign w_qbit     = ~w_diff[XLEN+1];
  assign w_div_next = {(w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                       r_acc[XLEN-2:0], w_qbit};

  // ---------------- result correction ----------------
  // Divide results are zero-extended before negation; only the low word is kept
  assign w_fix_in = r_f3[2] ? {{XLEN{1'b0}}, (r_f3[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0])}
                            : r_acc;

  mdu_sign_fix #(.W(2*XLEN)) u_fix (.i_val(w_fix_in), .i_neg(r_neg), .o_val(w_fixed));

  assign w_fix_word = (!r_f3[2] && (r_f3[1:0] != 2'b00)) ? w_fixed[2*XLEN-1:XLEN]
                                                         : w_fixed[XLEN-1:0];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; kill aborts only while the op is still in flight
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (start && !kill) w_state_nxt = w_special ? FIX : CALC;
      CALC: begin
        if (kill)                   w_state_nxt = IDLE;
        else if (r_cnt == CNT_LAST) w_state_nxt = FIX;
      end
      FIX:  w_state_nxt = kill ? IDLE : DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept and one iteration per CALC cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_f3       <= '0;
      r_rd       <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_neg      <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= '0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_f3       <= funct3;
      r_rd       <= rd_in;
      r_acc      <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
      r_opnd     <= w_is_div ? w_abs_b : w_abs_a;
      r_neg      <= (funct3[2] && funct3[1]) ? w_sa : (w_sa ^ w_sb);
      r_special  <= w_special;
      r_spec_val <= w_spec_val;
    end else if (r_state == CALC && !kill) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_acc <= r_f3[2] ? w_div_next : w_mul_next;
    end
  end

  // Result register; updated only by a FIX that is not killed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_result <= '0;
    else if (r_state == FIX && !kill)  r_result <= r_special ? r_spec_val : w_fix_word;
  end

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign wb_en  = done && (r_rd != 5'd0);
  assign result = r_result;
  assign rd_out = r_rd;

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed vector table, hazard sequences and
// random ops checked against a plain-arithmetic reference model.
module tb_mdu_iterative;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_result;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mdu_iterative #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
    .wb_en(wb_en), .result(result), .rd_out(rd_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics from wide signed/unsigned arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    p  = '0;
    case (f3)
      F3_MUL:    begin p = sa * sb; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; p = q; return p[31:0];
      end
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; p = q; return p[31:0];
      end
      F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    bit sp;
    sp = f3[2] && ((b == 0) ||
                   ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return sp ? 2 : 34;
  endfunction

  function automatic void add_vec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd, input logic [31:0] exp, input int lat);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // Present an op for exactly one rising edge, then scramble the inputs
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    funct3 = 3'($urandom_range(0, 7));
    rd_in  = 5'($urandom_range(0, 31));
  endtask

  task automatic run_vec(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_lat);
    int lat;
    bit busy_bad, seen;
    issue(f3, a, b, rd);
    lat = 0; busy_bad = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (!busy) busy_bad = 1;
      if (done)  seen = 1;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'(1));
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_result"}, 64'(result), 64'(exp_res));
    chk({tag, "_rd_out"}, 64'(rd_out), 64'(rd));
    chk({tag, "_wb_en"}, 64'(wb_en), 64'(rd != 5'd0));
    chk({tag, "_busy_held"}, 64'(busy_bad), 64'(0));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(done), 64'(0));
    chk({tag, "_idle_after"}, 64'(busy), 64'(0));
    last_result = exp_res;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, done_cyc;
    logic [31:0] res_at_done, ea, eb;
    logic [2:0]  f3;
    logic [4:0]  rd;

    rst = 1'b0; start = 1'b0; kill = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    last_result = '0;

    add_vec(F3_MUL,    32'd7,        32'd6,        5'd5,  32'h0000_002A, 34);
    add_vec(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 34);
    add_vec(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 34);
    add_vec(F3_MULHSU, 32'hFFFF_FFFF, 32'd2,        5'd3,  32'hFFFF_FFFF, 34);
    add_vec(F3_DIV,    32'hFFFF_FFF9, 32'd2,        5'd4,  32'hFFFF_FFFD, 34);
    add_vec(F3_REM,    32'hFFFF_FFF9, 32'd2,        5'd6,  32'hFFFF_FFFF, 34);
    add_vec(F3_DIVU,   32'd100,      32'd7,        5'd7,  32'd14,        34);
    add_vec(F3_REMU,   32'd100,      32'd7,        5'd8,  32'd2,         34);
    add_vec(F3_DIVU,   32'h1234,     32'd0,        5'd9,  32'hFFFF_FFFF, 2);
    add_vec(F3_REMU,   32'h1234,     32'd0,        5'd10, 32'h0000_1234, 2);
    add_vec(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 2);
    add_vec(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 2);
    add_vec(F3_DIV,    32'd5,        32'd0,        5'd13, 32'hFFFF_FFFF, 2);
    add_vec(F3_REM,    32'hFFFF_FFFB, 32'd0,        5'd14, 32'hFFFF_FFFB, 2);
    add_vec(F3_MUL,    32'hFFFF_FFFF, 32'd3,        5'd15, 32'hFFFF_FFFD, 34);
    add_vec(F3_MUL,    32'd5,        32'd5,        5'd0,  32'd25,        34);

    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_wb_en", 64'(wb_en), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_rd_out", 64'(rd_out), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i])
      run_vec($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
              vecs[i].exp, vecs[i].lat);

    // start pulsed mid-operation is ignored
    ea = 32'h0001_2345; eb = 32'h0000_0010;
    issue(F3_MUL, ea, eb, 5'd17);
    ndone = 0; done_cyc = 0; res_at_done = '0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 10) begin
        start = 1'b1; funct3 = F3_DIVU; op_a = 32'd9; op_b = 32'd0; rd_in = 5'd21;
      end
      if (c == 11) start = 1'b0;
      if (done) begin ndone++; done_cyc = c; res_at_done = result; end
    end
    chk("start_busy_done_count", 64'(ndone), 64'(1));
    chk("start_busy_done_cycle", 64'(done_cyc), 64'(34));
    chk("start_busy_result", 64'(res_at_done), 64'(ref_result(F3_MUL, ea, eb)));
    chk("start_busy_idle_end", 64'(busy), 64'(0));
    last_result = ref_result(F3_MUL, ea, eb);

    // kill at cycle 20 of a divide
    issue(F3_DIVU, 32'hDEAD_BEEF, 32'd13, 5'd22);
    for (int c = 1; c < 20; c++) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    chk("kill_busy_falls", 64'(busy), 64'(0));
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("kill_no_done", 64'(ndone), 64'(0));
    chk("kill_result_kept", 64'(result), 64'(last_result));

    // kill together with start in IDLE
    @(negedge clk);
    start = 1'b1; kill = 1'b1; funct3 = F3_MUL; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd1;
    @(posedge clk);
    #1 begin start = 1'b0; kill = 1'b0; end
    @(negedge clk);
    chk("kill_start_idle", 64'(busy), 64'(0));

    // kill during DONE does not cut the pulse
    issue(F3_DIVU, 32'h55, 32'd0, 5'd3);
    @(posedge clk);
    #1 kill = 1'b1;
    @(negedge clk);
    chk("kill_done_pulse", 64'(done), 64'(1));
    chk("kill_done_result", 64'(result), 64'hFFFF_FFFF);
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    chk("kill_done_idle", 64'(busy), 64'(0));

    // asynchronous reset in the middle of a divide
    issue(F3_DIV, 32'hFFFF_FF9C, 32'd7, 5'd9);
    repeat (15) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_result", 64'(result), 64'(0));
    chk("midrst_rd_out", 64'(rd_out), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    run_vec("after_rst_mul", F3_MUL, 32'd3, 32'd3, 5'd7, 32'd9, 34);

    // random ops against the reference model
    for (int n = 0; n < 150; n++) begin
      f3 = 3'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 9))
        0:       begin ea = $urandom; eb = 32'd0; end
        1:       begin ea = 32'h8000_0000; eb = 32'hFFFF_FFFF; end
        2:       begin ea = 32'($urandom_range(0, 300)); eb = 32'($urandom_range(1, 20)); end
        3:       begin ea = $urandom; eb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)); end
        default: begin ea = $urandom; eb = $urandom; end
      endcase
      run_vec($sformatf("rand%0d", n), f3, ea, eb, rd, ref_result(f3, ea, eb),
              ref_latency(f3, ea, eb));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
Iterative RV32M multiply/divide unit between operand read and writeback.
- Consumes the two register-file read operands plus the destination index.
- Computes one M-extension result over multiple cycles.
- Returns result, destination index and a one-cycle write-enable for the register-file write port.
- Pipeline control stalls on busy.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset (0 = reset asserted)
- start  input  1  request; sampled only in IDLE
- kill  input  1  synchronous flush; abandons in-flight op
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value (dividend / multiplicand)
- op_b  input  XLEN  rs2 value (divisor / multiplier)
- rd_in  input  5  destination register index
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle result-valid pulse
- wb_en  output  1  done AND (rd_out != 0); drives register-file write enable
- result  output  XLEN  result, held until next accepted op
- rd_out  output  5  captured destination index

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, done=0, wb_en=0, result=0, rd_out=0; counter and datapath registers cleared.
- States:
  - IDLE -> CALC when start.
  - IDLE -> FIX when start is a special divide case.
  - CALC -> FIX after XLEN iterations.
  - FIX -> DONE.
  - DONE -> IDLE unconditionally.
- Accept (IDLE & start at an edge):
  - Latch funct3, rd_in.
  - Latch |op_a| and |op_b| per signedness: MULH both signed; MULHSU a signed, b unsigned; DIV/REM both signed; others unsigned.
  - Record result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- CALC:
  - Multiply: shift-add, 2*XLEN product accumulator.
  - Divide: restoring divide, one quotient bit per cycle.
  - Counter runs 0..XLEN-1.
- FIX:
  - Apply two's-complement negation per recorded sign.
  - Select low word (MUL), high word (MULH*), quotient or remainder.
  - Register into result.
- DONE: done=1 for exactly this cycle; result and rd_out valid; wb_en as defined.
- Latency, counted from the accept edge:
  - Normal ops: done visible in the cycle after edge XLEN+2 (34 edges).
  - Special cases: done visible after edge 2.
- Special cases (bypass CALC):
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- MUL result is independent of signedness.
- MULHU/MULHSU use the full unsigned 64-bit product before sign fix.
- start while busy (including DONE): ignored; no queuing.
- kill:
  - In CALC or FIX: next state IDLE; no done pulse; result keeps its previous value.
  - In DONE: no effect (pulse completes).
  - kill together with start in IDLE: start is ignored.
- Async reset mid-operation: immediate IDLE with all outputs at reset values; no done pulse.
- Inputs are not required to be held after the accept edge.

Decomposition:
- Shared package mdu_pkg holds:
  - funct3 localparams (F3_MUL..F3_REMU).
  - State encoding (IDLE, CALC, FIX, DONE).
  - XLEN default.
- One sub-module, mdu_sign_fix: combinational abs/negate helper, instantiated for operand preparation and result correction.
- Sequencing and datapath stay in mdu_iterative.

Test Plan:
- MUL, a=7, b=6, rd_in=5: done at cycle 34 after accept, result=0x0000002A, rd_out=5, wb_en=1; busy high for cycles 1..34.
- MULH a=b=0xFFFFFFFF -> result 0x00000000. MULHU same operands -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU same operands -> 2.
- Special cases complete in 2 cycles with no CALC:
  - DIVU a=0x1234, b=0 -> 0xFFFFFFFF.
  - REMU a=0x1234, b=0 -> 0x1234.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Hazards:
  - start pulsed at cycle 10 of a running op -> ignored; exactly one done.
  - kill at cycle 20 -> busy falls the next cycle, no done, result unchanged.
  - rd_in=0 -> done=1, wb_en=0.
- Drop rst at cycle 15 of a DIV -> busy, done, result and rd_out read 0 immediately. After release, MUL 3*3 -> 9 with normal latency.
